// File: rtl/snake_pkg.sv
// snake_pkg: direction encoding and helpers shared by the snake control blocks.
package snake_pkg;
    localparam int DIR_W = 3;
    typedef logic [DIR_W-1:0] dir_t;
    localparam dir_t DIR_UP    = 3'd1;
    localparam dir_t DIR_DOWN  = 3'd2;
    localparam dir_t DIR_LEFT  = 3'd3;
    localparam dir_t DIR_RIGHT = 3'd4;
    function automatic dir_t dir_opposite(input dir_t d);
        return d == DIR_UP ? DIR_DOWN : d == DIR_DOWN ? DIR_UP : d == DIR_LEFT ? DIR_RIGHT : DIR_LEFT;
    endfunction
endpackage

// File: rtl/step_timer.sv
// step_timer: counts run-enabled cycles and flags the cycle where the period wraps.
module step_timer #(
    parameter int DIV = 3000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clr,
    output logic tick_o
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic wrap;
    always_comb begin
        wrap = run && !clr && cnt_q == CW'(DIV - 1);
        cnt_d = clr ? '0 : !run ? cnt_q : wrap ? '0 : cnt_q + CW'(1);
        tick_o = wrap;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/dir_cmd_queue.sv
// dir_cmd_queue: queues legal button-press direction commands and pops one per snake step.
module dir_cmd_queue
    import snake_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int STEP_DIV = 3000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               btn_level,
    input  logic                     run,
    input  logic                     flush,
    output logic                     step_o,
    output logic [DIR_W-1:0]         dir_o,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    dir_t mem_q [0:DEPTH-1];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] cnt_q, cnt_d;
    dir_t dir_q, dir_d, cand, ref_dir;
    logic [3:0] prev_q, rise;
    logic step_q, ovf_q, ovf_d, tick, legal, pop, push;

    step_timer #(.DIV(STEP_DIV)) u_timer (
        .clk(clk), .reset_n(reset_n), .run(run), .clr(flush), .tick_o(tick)
    );

    // New presses are judged against the newest queued command, not the current heading.
    always_comb begin
        rise = btn_level & ~prev_q;
        cand = rise[0] ? DIR_UP : rise[1] ? DIR_DOWN : rise[2] ? DIR_LEFT : DIR_RIGHT;
        ref_dir = cnt_q != '0 ? mem_q[tail_q - PW'(1)] : dir_q;
        legal = run && !flush && |rise && cand != ref_dir && cand != dir_opposite(ref_dir);
        pop = tick && cnt_q != '0;
        push = legal && (cnt_q != FULL || pop);
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        dir_d = flush ? DIR_RIGHT : pop ? mem_q[head_q] : dir_q;
        ovf_d = !flush && (ovf_q || (legal && !push));
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            prev_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q <= '0;
            dir_q <= DIR_RIGHT;
            step_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            prev_q <= btn_level;
            head_q <= flush ? '0 : head_q + PW'(pop);
            tail_q <= flush ? '0 : tail_q + PW'(push);
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            step_q <= tick;
            ovf_q <= ovf_d;
        end

    always_ff @(posedge clk)
        if (push) mem_q[tail_q] <= cand;

    assign step_o = step_q;
    assign dir_o = dir_q;
    assign q_count = cnt_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_dir_cmd_queue.sv
// tb_dir_cmd_queue: directed stimulus with a reference model and a scoreboard of expected step directions.
module tb_dir_cmd_queue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] btn_level = '0;
    logic run = 1'b0;
    logic flush = 1'b0;
    logic step_o;
    logic [2:0] dir_o;
    logic [2:0] q_count;
    logic overflow;

    int checks = 0;
    int errors = 0;
    logic [2:0] sbq[$];
    logic [2:0] m_dir = 3'd4;
    logic [3:0] m_prev = '0;
    int m_cnt = 0;
    logic m_ovf = 1'b0;
    logic [2:0] pd_last = 3'd4;
    int seq_a[4] = '{1, 3, 2, 3};
    int seq_b[4] = '{3, 2, 3, 1};

    dir_cmd_queue #(.DEPTH(4), .STEP_DIV(8)) dut (
        .clk(clk), .reset_n(reset_n), .btn_level(btn_level), .run(run), .flush(flush),
        .step_o(step_o), .dir_o(dir_o), .q_count(q_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] opp(input logic [2:0] d);
        return d == 3'd1 ? 3'd2 : d == 3'd2 ? 3'd1 : d == 3'd3 ? 3'd4 : 3'd3;
    endfunction

    task automatic model_reset();
        sbq.delete();
        m_dir = 3'd4;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_prev = '0;
    endtask

    // Advance one clock: predict from current inputs, then sample 1 time unit after the edge.
    task automatic cyc();
        logic [3:0] r;
        logic [2:0] c, rf;
        bit legal, pop, es;
        r = btn_level & ~m_prev;
        es = 0;
        if (!reset_n) model_reset();
        else if (flush) begin
            sbq.delete();
            m_dir = 3'd4;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            es = run && m_cnt == 7;
            if (run) m_cnt = m_cnt == 7 ? 0 : m_cnt + 1;
            c = r[0] ? 3'd1 : r[1] ? 3'd2 : r[2] ? 3'd3 : 3'd4;
            rf = m_dir;
            if (sbq.size() != 0) rf = sbq[$];
            legal = run && r != 0 && c != rf && c != opp(rf);
            pop = es && sbq.size() != 0;
            if (legal && sbq.size() == 4 && !pop) m_ovf = 1'b1;
            if (pop) begin
                pd_last = sbq.pop_front();
                m_dir = pd_last;
            end else pd_last = m_dir;
            if (legal && sbq.size() < 4) sbq.push_back(c);
        end
        m_prev = reset_n ? btn_level : 4'b0;
        @(posedge clk);
        #1;
        chk("step_o", step_o, es);
        chk("dir_o", dir_o, m_dir);
        chk("q_count", q_count, sbq.size());
        chk("overflow", overflow, m_ovf);
        if (step_o) chk("pop_dir", dir_o, pd_last);
    endtask

    task automatic wait_step();
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!step_o && n < 20);
        chk("step_seen", step_o, 1);
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_dir", dir_o, 4);
        chk("rst_q", q_count, 0);
        reset_n = 1'b1;
        cyc();
        run = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            cyc();
            chk("t1_step", step_o, (i % 8) == 0);
        end
        chk("t1_dir", dir_o, 4);
        btn_level = 4'b0100;
        cyc();
        chk("t3_reversal", q_count, 0);
        btn_level = 4'b0000;
        cyc();
        btn_level = 4'b1000;
        cyc();
        chk("t3_duplicate", q_count, 0);
        btn_level = 4'b0000;
        cyc();
        cyc();
        btn_level = 4'b0001;
        cyc();
        chk("t2_push", q_count, 1);
        btn_level = 4'b0000;
        wait_step();
        chk("t2_dir", dir_o, 1);
        chk("t2_q", q_count, 0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        btn_level = 4'b0001; cyc();
        btn_level = 4'b0100; cyc();
        btn_level = 4'b0010; cyc();
        btn_level = 4'b0100; cyc();
        chk("t4_full", q_count, 4);
        chk("t4_no_ovf", overflow, 0);
        btn_level = 4'b0001; cyc();
        chk("t4_q_after_drop", q_count, 4);
        chk("t4_ovf", overflow, 1);
        btn_level = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_step();
            chk("t4_seq", dir_o, seq_a[k]);
            chk("t4_q", q_count, 3 - k);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        btn_level = 4'b0001; cyc();
        btn_level = 4'b0100; cyc();
        btn_level = 4'b0010; cyc();
        btn_level = 4'b0100; cyc();
        btn_level = 4'b0000; cyc(); cyc(); cyc();
        btn_level = 4'b0001; cyc();
        chk("t5_step", step_o, 1);
        chk("t5_dir", dir_o, 1);
        chk("t5_q", q_count, 4);
        chk("t5_ovf", overflow, 0);
        btn_level = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_step();
            chk("t5_seq", dir_o, seq_b[k]);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        btn_level = 4'b1010; cyc();
        chk("t6_prio", q_count, 1);
        btn_level = 4'b0100; cyc();
        btn_level = 4'b0001; cyc();
        btn_level = 4'b1000; cyc();
        btn_level = 4'b0001; cyc();
        chk("t6_full", q_count, 4);
        chk("t6_ovf", overflow, 1);
        btn_level = 4'b0000;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t6_flush_q", q_count, 0);
        chk("t6_flush_dir", dir_o, 4);
        chk("t6_flush_ovf", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("t6_step_after_flush", step_o, i == 8);
        end
        btn_level = 4'b0001; cyc();
        btn_level = 4'b0000;
        wait_step();
        chk("t6_pre_rst_dir", dir_o, 1);
        btn_level = 4'b0100; cyc();
        btn_level = 4'b0000; cyc();
        chk("t6_pre_rst_q", q_count, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_dir", dir_o, 4);
        chk("arst_q", q_count, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_step", step_o, 0);
        model_reset();
        cyc();
        reset_n = 1'b1;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
